reqack_arb: RTL and testbench

// - N-channel toggle req/ack receiver presented as one FIFO-style read port with a channel index.
// - Each channel's requester lives in another clock domain and flips req[i] to post a request with payload.
// - Per-channel synchronisers feed an arbiter (round-robin or fixed priority) that grants one request at a time.
// - Acknowledge by pulsing re: ack[ch] flips and the next pending channel is granted.
// - Sits between N async command sources and a single local consumer, e.g. a register engine or DMA kick-off.
//

---
 rtl/reqack_pkg.sv | 30 +++
 rtl/reqack_arb_if.sv | 31 +++
 rtl/reqack_sync_n.sv | 30 +++
 rtl/reqack_arb.sv | 109 ++++++++++
 tb/tb_reqack_arb.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/reqack_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reqack_pkg: shared types, arbitration-mode constants and width helpers.
// Rev 1.0
// ----------------------------------------------------------------------------
package reqack_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int idx_width(input int channels);
    return (channels <= 1) ? 1 : clog2(channels);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reqack_arb_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reqack_arb_if: request/payload/ack bundle plus the consumer read port.
// Rev 1.0
// ----------------------------------------------------------------------------
interface reqack_arb_if #(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 32
) ();
  localparam int IDX_WIDTH = reqack_pkg::idx_width(CHANNELS);

  logic [CHANNELS-1:0]            req;
  logic [CHANNELS*DATA_WIDTH-1:0] req_data;
  logic [CHANNELS-1:0]            ack;
  logic                           ne;
  logic [IDX_WIDTH-1:0]           ch;
  logic [DATA_WIDTH-1:0]          rd_data;
  logic                           re;
  logic [CHANNELS-1:0]            pending;

  modport slave (
    input  req, req_data, re,
    output ack, ne, ch, rd_data, pending
  );

  modport master (
    output req, req_data, re,
    input  ack, ne, ch, rd_data, pending
  );
endinterface
`default_nettype wire

// File: rtl/reqack_sync_n.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reqack_sync_n: WIDTH-bit multi-flop synchroniser with synchronous reset.
// Rev 1.0
// ----------------------------------------------------------------------------
module reqack_sync_n #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/reqack_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reqack_arb: N-channel toggle req/ack receiver behind one arbitrated read port.
// Rev 1.0
// ----------------------------------------------------------------------------
module reqack_arb #(
  parameter int CHANNELS    = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int RR          = reqack_pkg::ARB_RR
) (
  input  logic         clk,
  input  logic         reset,
  reqack_arb_if.slave  bus
);
  import reqack_pkg::*;

  localparam int IDX_WIDTH = idx_width(CHANNELS);

  state_e                state_q, state_d;
  logic [CHANNELS-1:0]   ack_q, ack_d;
  logic [IDX_WIDTH-1:0]  ch_q, ch_d;
  logic [IDX_WIDTH-1:0]  ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CHANNELS-1:0]   req_s;
  logic [CHANNELS-1:0]   pending;
  logic [IDX_WIDTH-1:0]  win;

  reqack_sync_n #(
    .WIDTH  (CHANNELS),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus.req),
    .q_o   (req_s)
  );

  // Rotate so the slot after the pointer sits at bit 0, find first, unrotate.
  function automatic logic [IDX_WIDTH-1:0] pick(
    input logic [CHANNELS-1:0]  p,
    input logic [IDX_WIDTH-1:0] ptr
  );
    logic [2*CHANNELS-1:0] dbl;
    logic [CHANNELS-1:0]   rot;
    int start;
    int off;
    start = (RR == ARB_FIXED) ? 0 : (int'(ptr) + 1) % CHANNELS;
    dbl   = {p, p};
    rot   = CHANNELS'(dbl >> start);
    off   = 0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (rot[i]) off = i;
    end
    return IDX_WIDTH'((start + off) % CHANNELS);
  endfunction

  assign pending = req_s ^ ack_q;
  assign win     = pick(pending, ptr_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ack_q   <= '0;
      ch_q    <= '0;
      ptr_q   <= IDX_WIDTH'(CHANNELS - 1);
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (|pending) begin
          ch_d    = win;
          data_d  = DATA_WIDTH'(bus.req_data >> (int'(win) * DATA_WIDTH));
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (bus.re) begin
          ack_d[ch_q] = ~ack_q[ch_q];
          ptr_d       = ch_q;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.ack     = ack_q;
  assign bus.ne      = (state_q == ST_GRANT);
  assign bus.ch      = ch_q;
  assign bus.rd_data = data_q;
  assign bus.pending = pending;

endmodule
`default_nettype wire

// File: tb/tb_reqack_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_reqack_arb: directed self-checking bench for reqack_arb (RR and fixed).
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_reqack_arb;
  import reqack_pkg::*;

  localparam int CH = 4;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  reqack_arb_if #(.CHANNELS(CH), .DATA_WIDTH(DW)) b_rr ();
  reqack_arb_if #(.CHANNELS(CH), .DATA_WIDTH(DW)) b_fx ();

  reqack_arb #(.CHANNELS(CH), .DATA_WIDTH(DW), .SYNC_STAGES(2), .RR(ARB_RR)) u_rr (
    .clk   (clk),
    .reset (reset),
    .bus   (b_rr)
  );

  reqack_arb #(.CHANNELS(CH), .DATA_WIDTH(DW), .SYNC_STAGES(2), .RR(ARB_FIXED)) u_fx (
    .clk   (clk),
    .reset (reset),
    .bus   (b_fx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rr_ne(input string tag);
    for (int i = 0; i < 20 && b_rr.ne !== 1'b1; i++) tick();
    chk(tag, 64'(b_rr.ne), 64'd1);
  endtask

  task automatic pulse_rr_re();
    b_rr.re = 1'b1;
    tick();
    b_rr.re = 1'b0;
  endtask

  task automatic pulse_fx_re();
    b_fx.re = 1'b1;
    tick();
    b_fx.re = 1'b0;
  endtask

  initial begin
    b_rr.req = '0; b_rr.re = 1'b0;
    b_fx.req = '0; b_fx.re = 1'b0;
    for (int i = 0; i < CH; i++) begin
      b_rr.req_data[i*DW +: DW] = 32'hA5A5_0000 + 32'(i);
      b_fx.req_data[i*DW +: DW] = 32'hA5A5_0000 + 32'(i);
    end
    reset = 1'b1;
    tick(); tick(); tick();

    chk("rst_ack",     64'(b_rr.ack),     64'h0);
    chk("rst_ne",      64'(b_rr.ne),      64'h0);
    chk("rst_ch",      64'(b_rr.ch),      64'h0);
    chk("rst_rd_data", 64'(b_rr.rd_data), 64'h0);
    chk("rst_pending", 64'(b_rr.pending), 64'h0);
    reset = 1'b0;
    tick();

    // Round-robin: 0,1,3 together with re held high.
    b_rr.req = 4'b1011;
    b_rr.re  = 1'b1;
    tick(); tick(); tick();
    chk("rr_g0_ne",  64'(b_rr.ne),  64'd1);
    chk("rr_g0_ch",  64'(b_rr.ch),  64'd0);
    chk("rr_g0_ack", 64'(b_rr.ack), 64'b0000);
    tick();
    chk("rr_a0_ack", 64'(b_rr.ack), 64'b0001);
    chk("rr_a0_ne",  64'(b_rr.ne),  64'd0);
    tick();
    chk("rr_g1_ch",  64'(b_rr.ch),  64'd1);
    chk("rr_g1_rd",  64'(b_rr.rd_data), 64'hA5A5_0001);
    tick();
    chk("rr_a1_ack", 64'(b_rr.ack), 64'b0011);
    tick();
    chk("rr_g3_ch",  64'(b_rr.ch),  64'd3);
    tick();
    chk("rr_a3_ack", 64'(b_rr.ack), 64'b1011);
    chk("rr_a3_ne",  64'(b_rr.ne),  64'd0);
    b_rr.re = 1'b0;
    tick();

    // Single request latency on channel 2.
    b_rr.req = 4'b1111;
    tick(); tick();
    chk("lat_ne_early", 64'(b_rr.ne), 64'd0);
    tick();
    chk("lat_ne",      64'(b_rr.ne),      64'd1);
    chk("lat_ch",      64'(b_rr.ch),      64'd2);
    chk("lat_rd_data", 64'(b_rr.rd_data), 64'hA5A5_0002);
    chk("lat_pending", 64'(b_rr.pending), 64'b0100);
    pulse_rr_re();
    chk("lat_ack",     64'(b_rr.ack),     64'b1111);
    chk("lat_ne_off",  64'(b_rr.ne),      64'd0);
    chk("lat_pend_off", 64'(b_rr.pending), 64'b0000);

    // re while idle is ignored.
    pulse_rr_re();
    tick();
    chk("idle_re_ack", 64'(b_rr.ack), 64'b1111);
    chk("idle_re_ne",  64'(b_rr.ne),  64'd0);

    // Hold GRANT for 50 cycles while the source payload churns.
    b_rr.req = 4'b1101;
    wait_rr_ne("hold_ne");
    chk("hold_ch0", 64'(b_rr.ch), 64'd1);
    for (int i = 0; i < 50; i++) begin
      b_rr.req_data[1*DW +: DW] = $urandom;
      tick();
      chk("hold_ch", 64'(b_rr.ch),      64'd1);
      chk("hold_rd", 64'(b_rr.rd_data), 64'hA5A5_0001);
    end
    b_rr.req_data[1*DW +: DW] = 32'hA5A5_0001;
    pulse_rr_re();
    chk("hold_ack", 64'(b_rr.ack), 64'b1101);

    // Fixed priority: channel 0 re-posted beats channel 3.
    b_fx.req = 4'b1011;
    tick(); tick(); tick();
    chk("fx_g0_ch", 64'(b_fx.ch), 64'd0);
    chk("fx_g0_ne", 64'(b_fx.ne), 64'd1);
    b_fx.re = 1'b1;
    tick();
    b_fx.re  = 1'b0;
    b_fx.req = 4'b1010;
    chk("fx_a0_ack", 64'(b_fx.ack), 64'b0001);
    tick();
    chk("fx_g1_ch", 64'(b_fx.ch), 64'd1);
    tick(); tick();
    chk("fx_pending", 64'(b_fx.pending), 64'b1011);
    pulse_fx_re();
    chk("fx_a1_ack", 64'(b_fx.ack), 64'b0011);
    tick();
    chk("fx_g0b_ch", 64'(b_fx.ch), 64'd0);
    pulse_fx_re();
    chk("fx_a0b_ack", 64'(b_fx.ack), 64'b0010);
    tick();
    chk("fx_g3_ch", 64'(b_fx.ch), 64'd3);
    pulse_fx_re();
    chk("fx_a3_ack", 64'(b_fx.ack), 64'b1010);

    // Reset while granted with ack=0101.
    reset    = 1'b1;
    b_rr.req = '0;
    b_fx.req = '0;
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    b_rr.req = 4'b0101;
    wait_rr_ne("mr_g0_ne");
    chk("mr_g0_ch", 64'(b_rr.ch), 64'd0);
    pulse_rr_re();
    wait_rr_ne("mr_g2_ne");
    chk("mr_g2_ch", 64'(b_rr.ch), 64'd2);
    pulse_rr_re();
    chk("mr_ack", 64'(b_rr.ack), 64'b0101);
    b_rr.req = 4'b0111;
    wait_rr_ne("mr_g1_ne");
    chk("mr_g1_ch", 64'(b_rr.ch), 64'd1);
    reset = 1'b1;
    tick();
    chk("mr_rst_ack", 64'(b_rr.ack),     64'h0);
    chk("mr_rst_ne",  64'(b_rr.ne),      64'h0);
    chk("mr_rst_rd",  64'(b_rr.rd_data), 64'h0);
    reset = 1'b0;
    tick(); tick();
    chk("mr_re_early", 64'(b_rr.ne), 64'd0);
    tick();
    chk("mr_re_ne", 64'(b_rr.ne),      64'd1);
    chk("mr_re_ch", 64'(b_rr.ch),      64'd0);
    chk("mr_re_rd", 64'(b_rr.rd_data), 64'hA5A5_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
